// File: rtl/bf_fetch_pkg.sv
// Shared types and defaults for the Balsa result-fetch block.
// Holds the handshake FSM encoding and the FIFO occupancy-width helper.
package bf_fetch_pkg;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RTZ  = 2'd2
   } fetch_state_e;

   // Occupancy must be able to represent DEPTH itself, hence the extra bit.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Small synchronous FIFO with a registered head; no fall-through.
// dout holds its last value while the FIFO is empty.
module bf_sync_fifo
   import bf_fetch_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] dout,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          do_push, do_pop;

   assign do_push = push && (count_q != CW'(DEPTH));
   assign do_pop  = pop && valid_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
      valid_d = (count_d != '0);
      // The new head may be the word being written this very edge.
      if (valid_d) begin
         if (do_push && (wr_ptr_q == rd_ptr_d)) dout_d = din;
         else                                   dout_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign full  = (count_q == CW'(DEPTH));
   assign empty = !valid_q;
   assign dout  = dout_q;
   assign count = count_q;

endmodule

// File: rtl/bf_result_fetch.sv
// Active-side 4-phase RTZ pull fetcher feeding a valid/ready FIFO.
// Define BF_FETCH_ACK_SYNC_EN to pass bf_a through a 2-flop synchronizer.
//
// state | meaning
// IDLE  | no handshake; may raise bf_r if enabled, space free, ack low
// REQ   | bf_r high, waiting for ack; data captured when ack seen
// RTZ   | bf_r low, waiting for ack to return to zero
module bf_result_fetch
   import bf_fetch_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   output logic                      bf_r,
   input  logic                      bf_a,
   input  logic [DW-1:0]             bf_d,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DW-1:0]             m_data,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      busy
);

   fetch_state_e state_q, state_d;
   logic         bf_r_q, bf_r_d;
   logic         busy_q;
   logic         ack_s;
   logic         push;
   logic         fifo_full, fifo_empty;

`ifdef BF_FETCH_ACK_SYNC_EN
   logic ack_meta_q, ack_sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_meta_q <= 1'b0;
         ack_sync_q <= 1'b0;
      end else begin
         ack_meta_q <= bf_a;
         ack_sync_q <= ack_meta_q;
      end
   end

   assign ack_s = ack_sync_q;
`else
   assign ack_s = bf_a;
`endif

   always_comb begin
      state_d = state_q;
      bf_r_d  = bf_r_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Ack must be low so a container still finishing RTZ is not re-requested.
            if (enable && !fifo_full && !ack_s) begin
               state_d = REQ;
               bf_r_d  = 1'b1;
            end
         end
         REQ: begin
            bf_r_d = 1'b1;
            if (ack_s) begin
               state_d = RTZ;
               bf_r_d  = 1'b0;
               push    = 1'b1;
            end
         end
         RTZ: begin
            bf_r_d = 1'b0;
            if (!ack_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            bf_r_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bf_r_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bf_r_q  <= bf_r_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   bf_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (bf_d),
      .pop   (m_valid && m_ready),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (m_data),
      .count (count)
   );

   assign bf_r    = bf_r_q;
   assign busy    = busy_q;
   assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_bf_result_fetch.sv
// Directed bench for bf_result_fetch: cycle table plus handshake sequences
// driven by a simple container model that answers requests with source data.
module tb_bf_result_fetch;
   import bf_fetch_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst, enable, bf_a, m_ready;
   logic [DW-1:0] bf_d;
   logic          bf_r, m_valid, busy;
   logic [DW-1:0] m_data;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   bf_result_fetch #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .bf_r    (bf_r),
      .bf_a    (bf_a),
      .bf_d    (bf_d),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .count   (count),
      .busy    (busy)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic       a;
      logic [7:0] d;
      logic       rdy;
      logic       e_r;
      logic       e_v;
      logic [7:0] e_data;
      logic [2:0] e_cnt;
      logic       e_busy;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // container model state
   bit            auto_ack = 1'b0;
   int            ack_dly = 0;
   int            wait_c = 0;
   logic [DW-1:0] src [16];
   int            src_n = 0;
   int            src_idx = 0;
   int            cyc_n = 0;
   int            n_req = 0;
   int            rise_last = 0;
   int            rise_prev = 0;
   logic          bf_r_prev = 1'b0;
   int            pop_idx = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock; outputs are sampled 1 ns after the edge, then the container reacts.
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      if (bf_r && !bf_r_prev) begin
         n_req++;
         rise_prev = rise_last;
         rise_last = cyc_n;
      end
      bf_r_prev = bf_r;
      if (auto_ack) begin
         if (bf_r && !bf_a) begin
            if (wait_c >= ack_dly && src_idx < src_n) begin
               bf_a = 1'b1;
               bf_d = src[src_idx];
               src_idx++;
               wait_c = 0;
            end else begin
               wait_c++;
            end
         end else if (!bf_r && bf_a) begin
            bf_a = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; bf_a = 1'b0; bf_d = '0; m_ready = 1'b0;
      auto_ack = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      wait_c = 0; src_idx = 0; n_req = 0; bf_r_prev = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl [15];
      rst = 1'b1; enable = 1'b0; bf_a = 1'b0; bf_d = '0; m_ready = 1'b0;

      do_reset();
      chk("reset.bf_r",    bf_r,    0);
      chk("reset.m_valid", m_valid, 0);
      chk("reset.m_data",  m_data,  0);
      chk("reset.count",   count,   0);
      chk("reset.busy",    busy,    0);

`ifndef BF_FETCH_ACK_SYNC_EN
      //            rst   en    a     d      rdy  | bf_r  valid data   cnt   busy
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 3'd1, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 3'd0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 3'd1, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 3'd1, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 3'd1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h77, 3'd0, 1'b0};

      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].rst; enable = tbl[i].en; bf_a = tbl[i].a;
         bf_d = tbl[i].d; m_ready = tbl[i].rdy;
         cyc();
         chk($sformatf("t%0d.bf_r", i),    bf_r,    tbl[i].e_r);
         chk($sformatf("t%0d.m_valid", i), m_valid, tbl[i].e_v);
         chk($sformatf("t%0d.m_data", i),  m_data,  tbl[i].e_data);
         chk($sformatf("t%0d.count", i),   count,   tbl[i].e_cnt);
         chk($sformatf("t%0d.busy", i),    busy,    tbl[i].e_busy);
      end

      // FIFO fills to DEPTH with consumer stalled; one pop frees a slot.
      do_reset();
      for (int i = 0; i < 5; i++) src[i] = 8'(8'h11 * (i + 1));
      src_n = 5; ack_dly = 0; auto_ack = 1'b1; enable = 1'b1;
      repeat (20) cyc();
      chk("full.count",  count,  4);
      chk("full.nreq",   n_req,  4);
      chk("full.bf_r",   bf_r,   0);
      chk("full.head",   m_data, 8'h11);
      chk("full.period", rise_last - rise_prev, 3);
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
      chk("pop1.count", count, 3);
      chk("pop1.bf_r",  bf_r,  0);
      cyc();
      chk("refill.bf_r", bf_r, 1);
      repeat (6) cyc();
      chk("refill.count", count, 4);
      chk("refill.nreq",  n_req, 5);
      m_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         chk($sformatf("drain%0d.valid", k), m_valid, 1);
         chk($sformatf("drain%0d.data", k),  m_data,  src[k]);
         cyc();
      end
      chk("drain.empty", m_valid, 0);

      // Reset while in REQ with ack high; ack held afterwards must block requests.
      do_reset();
      enable = 1'b1;
      cyc();
      chk("rmid.req", bf_r, 1);
      bf_a = 1'b1; bf_d = 8'h99; rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rmid.bf_r",    bf_r,    0);
      chk("rmid.busy",    busy,    0);
      chk("rmid.count",   count,   0);
      chk("rmid.m_valid", m_valid, 0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("rmid.hold%0d", k), bf_r, 0);
      end
      bf_a = 1'b0;
      cyc();
      chk("rmid.rereq", bf_r, 1);
      bf_a = 1'b1; bf_d = 8'h42;
      cyc();
      bf_a = 1'b0;
      cyc();
      chk("rmid.count2", count,  1);
      chk("rmid.data",   m_data, 8'h42);

      // Push and pop on the same edge at count 2, then order across pointer wrap.
      do_reset();
      for (int i = 0; i < 10; i++) src[i] = 8'(8'h13 * i + 8'h01);
      src_n = 10; ack_dly = 0; auto_ack = 1'b1; enable = 1'b1; pop_idx = 0;
      for (int t = 0; t < 100 && !(count == 2 && bf_r && bf_a); t++) cyc();
      chk("pp.reach", (count == 2 && bf_r && bf_a), 1);
      m_ready = 1'b1;
      chk("pp.head", m_data, src[0]);
      pop_idx = 1;
      cyc();
      chk("pp.count", count,  2);
      chk("pp.head2", m_data, src[1]);
      for (int t = 0; t < 200 && pop_idx < 10; t++) begin
         if (m_valid && m_ready) begin
            chk($sformatf("wrap.pop%0d", pop_idx), m_data, src[pop_idx]);
            pop_idx++;
         end
         cyc();
      end
      chk("wrap.pops", pop_idx, 10);
      repeat (3) cyc();
      chk("wrap.count", count,   0);
      chk("wrap.valid", m_valid, 0);
      chk("wrap.hold",  m_data,  src[9]);
`else
      // Synchronized ack: zero-delay container gives a 7-cycle transfer period.
      do_reset();
      src[0] = 8'h5A; src[1] = 8'h6B; src_n = 2;
      ack_dly = 0; auto_ack = 1'b1; enable = 1'b1;
      for (int t = 0; t < 40 && n_req < 2; t++) cyc();
      chk("sync.nreq",   n_req, 2);
      chk("sync.period", rise_last - rise_prev, 7);
      repeat (10) cyc();
      chk("sync.count", count,  2);
      chk("sync.data",  m_data, 8'h5A);

      // One-cycle ack glitch in IDLE must not write the FIFO.
      do_reset();
      bf_a = 1'b1; bf_d = 8'hEE;
      cyc();
      bf_a = 1'b0;
      repeat (6) cyc();
      chk("glitch.count", count,   0);
      chk("glitch.valid", m_valid, 0);
      chk("glitch.busy",  busy,    0);
      chk("glitch.bf_r",  bf_r,    0);
      enable = 1'b1;
      cyc();
      chk("glitch.req", bf_r, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
